uart_rx_fifo: RTL and testbench

Parametrised UART receiver with a buffered first-word-fall-through (FWFT) output FIFO. It is the next generation of the fixed 8N1 receiver used by the UART debug/loader path in top.
- Frame format is configurable: data bits, optional parity, 1 or 2 stop bits.
- Per-byte parity and framing flags are stored alongside each byte.
- Overrun is detected and reported.
- It sits between the board uart_rx pin and the debug loader / bus bridge.

---
 rtl/uart_rx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format feeding a first-word-fall-through FIFO
// that keeps per-byte parity and framing flags alongside the data.
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQ   = 50_000_000,
   parameter int unsigned UART_BPS   = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   input  logic                          clr_err,
   output logic                          busy
);

   localparam int unsigned DIV  = CLK_FREQ / UART_BPS;
   localparam int unsigned HALF = DIV / 2 - 1;
   localparam int unsigned CW   = $clog2(DIV);
   localparam int unsigned BW   = 4;
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned EW   = DATA_BITS + 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP
   } state_t;

   // Two-flop synchroniser plus previous-sample register for start-edge detection
   logic rx_meta;
   logic rx_s;
   logic rx_prev;
   logic start_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_c = ~rx_s & rx_prev;

   state_t               state;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_r;
   logic                 ferr_r;
   logic                 tick_c;

   assign tick_c = (baud_cnt == CW'(DIV - 1));

   // Receiver FSM: all sampling happens at mid-bit, DIV cycles apart
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         perr_r   <= 1'b0;
         ferr_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_c) begin
                  state    <= S_START;
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  perr_r   <= 1'b0;
                  ferr_r   <= 1'b0;
               end
            end
            S_START: begin
               if (baud_cnt == CW'(HALF)) begin
                  baud_cnt <= '0;
                  state    <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  baud_cnt <= '0;
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            S_PAR: begin
               if (tick_c) begin
                  baud_cnt <= '0;
                  perr_r   <= (PARITY == 1) ? ~^{shreg, rx_s} : ^{shreg, rx_s};
                  state    <= S_STOP;
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (tick_c) begin
                  baud_cnt <= '0;
                  if (!rx_s) ferr_r <= 1'b1;
                  if (bit_cnt == BW'(STOP_BITS - 1)) begin
                     bit_cnt <= '0;
                     state   <= S_IDLE;
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  baud_cnt <= baud_cnt + CW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   // The final stop sample is folded into the pushed flags directly
   logic          push_c;
   logic [EW-1:0] push_entry;

   assign push_c     = (state == S_STOP) && tick_c && (bit_cnt == BW'(STOP_BITS - 1));
   assign push_entry = {perr_r, ferr_r | ~rx_s, shreg};

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty_c;
   logic          full_c;
   logic          pop_c;
   logic          wr_en_c;
   logic          ovf_c;
   logic [EW-1:0] head;

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_c   = ~empty_c & rx_ready;
   assign wr_en_c = push_c & (~full_c | pop_c);
   assign ovf_c   = push_c & full_c & ~pop_c;

   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wr_ptr[AW-1:0]] <= push_entry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         overrun <= 1'b0;
      end else begin
         if (wr_en_c) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop_c)   rd_ptr <= rd_ptr + (AW+1)'(1);
         // A new overrun event takes priority over a clear in the same cycle
         if (ovf_c)        overrun <= 1'b1;
         else if (clr_err) overrun <= 1'b0;
      end
   end

   assign head       = mem[rd_ptr[AW-1:0]];
   assign rx_valid   = ~empty_c;
   assign rx_data    = empty_c ? '0 : head[DATA_BITS-1:0];
   assign rx_ferr    = ~empty_c & head[DATA_BITS];
   assign rx_perr    = ~empty_c & head[DATA_BITS+1];
   assign fifo_count = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 depth-16 instance and an 8E1 depth-4 instance.
module tb_uart_rx_fifo;

   localparam int unsigned CLK_FREQ = 50_000_000;
   localparam int unsigned UART_BPS = 10_000_000;
   localparam int unsigned DIV      = CLK_FREQ / UART_BPS;

   logic clk = 1'b0;
   logic rst;
   logic rx_a, rx_b;
   logic ready_a, ready_b;
   logic clr_a, clr_b;

   logic [7:0] data_a, data_b;
   logic       perr_a, perr_b, ferr_a, ferr_b;
   logic       valid_a, valid_b;
   logic [4:0] count_a;
   logic [2:0] count_b;
   logic       ovr_a, ovr_b, busy_a, busy_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
   ) u_a (
      .clk(clk), .rst(rst), .uart_rx(rx_a),
      .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
      .rx_valid(valid_a), .rx_ready(ready_a), .fifo_count(count_a),
      .overrun(ovr_a), .clr_err(clr_a), .busy(busy_a)
   );

   uart_rx_fifo #(
      .CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .DATA_BITS(8),
      .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_b (
      .clk(clk), .rst(rst), .uart_rx(rx_b),
      .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
      .rx_valid(valid_b), .rx_ready(ready_b), .fifo_count(count_b),
      .overrun(ovr_b), .clr_err(clr_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v);
      if (sel) rx_b = v;
      else     rx_a = v;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                             input logic pbit, input logic stopv);
      drive(sel, 1'b0);
      for (int i = 0; i < 8; i++) drive(sel, d[i]);
      if (use_par) drive(sel, pbit);
      drive(sel, stopv);
   endtask

   task automatic wait_valid_a(output int lat, output logic [7:0] d, output logic pe,
                               output logic fe);
      lat = 0;
      while (!valid_a && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      d  = data_a;
      pe = perr_a;
      fe = ferr_a;
   endtask

   task automatic pop_a();
      ready_a = 1'b1;
      @(negedge clk);
      ready_a = 1'b0;
   endtask

   task automatic pop_b();
      ready_b = 1'b1;
      @(negedge clk);
      ready_b = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      logic [7:0] cap_d;
      logic       cap_pe, cap_fe;
      logic [7:0] b2b  [6];
      logic [7:0] ovf_d [5];

      b2b   = '{8'h00, 8'h1F, 8'h01, 8'h3E, 8'h00, 8'h00};
      ovf_d = '{8'h11, 8'h23, 8'h07, 8'h80, 8'h5A};

      rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
      ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_valid", 32'(valid_a), 32'h0);
      chk("rst_count", 32'(count_a), 32'h0);
      chk("rst_overrun", 32'(ovr_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_data", 32'(data_a), 32'h0);

      // Single 8N1 frame, consumer always ready
      ready_a = 1'b1;
      fork
         send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
         wait_valid_a(lat, cap_d, cap_pe, cap_fe);
      join
      chk("a5_latency", 32'(lat >= 49 && lat <= 51), 32'h1);
      chk("a5_data", 32'(cap_d), 32'hA5);
      chk("a5_perr", 32'(cap_pe), 32'h0);
      chk("a5_ferr", 32'(cap_fe), 32'h0);
      repeat (2) @(negedge clk);
      chk("a5_count_after_pop", 32'(count_a), 32'h0);
      ready_a = 1'b0;

      // Back-to-back frames with no idle gap, consumer stalled
      for (int i = 0; i < 6; i++) send_frame(1'b0, b2b[i], 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("b2b_count", 32'(count_a), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("b2b_valid_%0d", i), 32'(valid_a), 32'h1);
         chk($sformatf("b2b_data_%0d", i), 32'(data_a), 32'(b2b[i]));
         chk($sformatf("b2b_flags_%0d", i), 32'({perr_a, ferr_a}), 32'h0);
         pop_a();
      end
      chk("b2b_drained", 32'(count_a), 32'h0);
      chk("empty_data_zero", 32'(data_a), 32'h0);

      // Even parity: 0x03 has two ones, so a parity bit of 1 is an error
      send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
      send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("par_count", 32'(count_b), 32'd2);
      chk("par_bad_data", 32'(data_b), 32'h03);
      chk("par_bad_perr", 32'(perr_b), 32'h1);
      pop_b();
      chk("par_good_data", 32'(data_b), 32'h03);
      chk("par_good_perr", 32'(perr_b), 32'h0);
      chk("par_good_ferr", 32'(ferr_b), 32'h0);
      pop_b();

      // Stop bit held low, then a clean frame after an idle gap
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
      rx_a = 1'b1;
      repeat (10) @(negedge clk);
      send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("ferr_count", 32'(count_a), 32'd2);
      chk("ferr_data", 32'(data_a), 32'h55);
      chk("ferr_flag", 32'(ferr_a), 32'h1);
      pop_a();
      chk("clean_data", 32'(data_a), 32'h66);
      chk("clean_ferr", 32'(ferr_a), 32'h0);
      pop_a();

      // Five frames into a depth-4 FIFO with the consumer stalled
      for (int i = 0; i < 5; i++) send_frame(1'b1, ovf_d[i], 1'b1, ^ovf_d[i], 1'b1);
      repeat (3) @(negedge clk);
      chk("ovf_count", 32'(count_b), 32'd4);
      chk("ovf_flag", 32'(ovr_b), 32'h1);
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      chk("ovf_cleared", 32'(ovr_b), 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_data_%0d", i), 32'(data_b), 32'(ovf_d[i]));
         chk($sformatf("ovf_perr_%0d", i), 32'(perr_b), 32'h0);
         pop_b();
      end
      chk("ovf_drained", 32'(count_b), 32'h0);

      // One-cycle low glitch: false start, nothing pushed
      rx_a = 1'b0;
      @(negedge clk);
      rx_a = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy", 32'(busy_a), 32'h1);
      repeat (8) @(negedge clk);
      chk("glitch_idle", 32'(busy_a), 32'h0);
      chk("glitch_count", 32'(count_a), 32'h0);

      // Reset in the middle of a frame, held until the line is idle again
      fork
         send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
         begin
            repeat (25) @(negedge clk);
            rst = 1'b1;
         end
      join
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_busy", 32'(busy_a), 32'h0);
      chk("midrst_count", 32'(count_a), 32'h0);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("post_rst_count", 32'(count_a), 32'd1);
      chk("post_rst_data", 32'(data_a), 32'h3C);
      chk("post_rst_flags", 32'({perr_a, ferr_a}), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
